// File: rtl/ab_pattern_gen_pkg.sv
// rtl/ab_pattern_gen_pkg.sv - shared state encodings, mode codes and vector mapping
package ab_pattern_gen_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic MODE_BIN  = 1'b0;
    localparam logic MODE_GRAY = 1'b1;

    // Gray order keeps a single-bit change between consecutive gate inputs
    function automatic logic [1:0] map_vec(input logic mode, input logic [1:0] idx);
        map_vec = (mode == MODE_GRAY) ? {idx[1], idx[1] ^ idx[0]} : idx;
    endfunction

endpackage

// File: rtl/ab_pattern_gen_if.sv
// rtl/ab_pattern_gen_if.sv - control and gate-stimulus signals of the A/B pattern generator
interface ab_pattern_gen_if #(
    parameter int HOLD_W = 8,
    parameter int LOOP_W = 4
);
    logic              start;
    logic              abort;
    logic              mode;
    logic [HOLD_W-1:0] hold_cycles;
    logic [LOOP_W-1:0] loops;
    logic              A;
    logic              B;
    logic              valid;
    logic              busy;
    logic              done;
    logic [1:0]        vec_idx;
    logic [LOOP_W-1:0] loop_cnt;

    modport master (
        output start, abort, mode, hold_cycles, loops,
        input  A, B, valid, busy, done, vec_idx, loop_cnt
    );

    modport slave (
        input  start, abort, mode, hold_cycles, loops,
        output A, B, valid, busy, done, vec_idx, loop_cnt
    );
endinterface

// File: rtl/ab_pattern_gen_hold_counter.sv
// rtl/ab_pattern_gen_hold_counter.sv - per-vector down counter, expires when it reads zero
module hold_counter #(
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [HOLD_W-1:0] i_load_val,
    output logic              o_expire
);
    logic [HOLD_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - HOLD_W'(1);
        end
    end

    assign o_expire = (r_cnt == '0);
endmodule

// File: rtl/ab_pattern_gen.sv
// rtl/ab_pattern_gen.sv - clocked sequencer stepping {A,B} through all four vectors
module ab_pattern_gen
    import ab_pattern_gen_pkg::*;
#(
    parameter int HOLD_W = 8,
    parameter int LOOP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    ab_pattern_gen_if.slave  bus
);
    logic [1:0]        r_state;
    logic              r_mode;
    logic [HOLD_W-1:0] r_hold_m1;
    logic [LOOP_W-1:0] r_loops;
    logic [LOOP_W-1:0] r_loop_cnt;
    logic [1:0]        r_vec_idx;
    logic              r_a;
    logic              r_b;
    logic              r_valid;

    logic              w_start_ok;
    logic              w_expire;
    logic              w_advance;
    logic              w_wrap;
    logic              w_last;
    logic [1:0]        w_idx_next;
    logic [LOOP_W-1:0] w_lc_next;
    logic [HOLD_W-1:0] w_hold_m1_in;
    logic [HOLD_W-1:0] w_load_val;

    assign w_start_ok   = (r_state == ST_IDLE) && bus.start && !bus.abort;
    // A hold of 0 behaves as 1, so the counter reload saturates at 0
    assign w_hold_m1_in = (bus.hold_cycles == '0) ? '0 : bus.hold_cycles - HOLD_W'(1);
    assign w_advance    = (r_state == ST_RUN) && !bus.abort && w_expire;
    assign w_load_val   = w_start_ok ? w_hold_m1_in : r_hold_m1;
    assign w_idx_next   = r_vec_idx + 2'd1;
    assign w_wrap       = (r_vec_idx == 2'd3);
    assign w_lc_next    = r_loop_cnt + LOOP_W'(1);
    assign w_last       = w_wrap && (w_lc_next == r_loops);

    hold_counter #(.HOLD_W(HOLD_W)) u_hold_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_start_ok || w_advance),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_mode     <= MODE_BIN;
            r_hold_m1  <= '0;
            r_loops    <= '0;
            r_loop_cnt <= '0;
            r_vec_idx  <= 2'd0;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_mode     <= bus.mode;
                        r_hold_m1  <= w_hold_m1_in;
                        r_loops    <= bus.loops;
                        r_loop_cnt <= '0;
                        r_vec_idx  <= 2'd0;
                        r_a        <= 1'b0;
                        r_b        <= 1'b0;
                        r_valid    <= (bus.loops != '0);
                        r_state    <= (bus.loops == '0) ? ST_FIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        r_state    <= ST_IDLE;
                        r_loop_cnt <= '0;
                        r_vec_idx  <= 2'd0;
                        r_a        <= 1'b0;
                        r_b        <= 1'b0;
                        r_valid    <= 1'b0;
                    end else if (w_expire) begin
                        r_vec_idx <= w_idx_next;
                        if (w_wrap) begin
                            r_loop_cnt <= w_lc_next;
                        end
                        if (w_last) begin
                            r_state <= ST_FIN;
                            r_valid <= 1'b0;
                            r_a     <= 1'b0;
                            r_b     <= 1'b0;
                        end else begin
                            {r_a, r_b} <= map_vec(r_mode, w_idx_next);
                        end
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    if (bus.abort) begin
                        r_loop_cnt <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.A        = r_a;
    assign bus.B        = r_b;
    assign bus.valid    = r_valid;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.done     = (r_state == ST_FIN);
    assign bus.vec_idx  = r_vec_idx;
    assign bus.loop_cnt = r_loop_cnt;
endmodule

// File: tb/tb_ab_pattern_gen.sv
// tb/tb_ab_pattern_gen.sv - scoreboard bench for ab_pattern_gen
module tb_ab_pattern_gen;

    typedef struct {
        logic       done;
        logic [1:0] ab;
        logic [1:0] idx;
        logic [3:0] lc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t e;
    logic [1:0] gray_lut [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    always #5 clk = ~clk;

    ab_pattern_gen_if #(.HOLD_W(8), .LOOP_W(4)) bus ();

    ab_pattern_gen #(.HOLD_W(8), .LOOP_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(negedge clk) begin
        if (rst_n && (bus.valid || bus.done)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: valid=%b done=%b AB=%b%b idx=%0d lc=%0d, scoreboard empty",
                         bus.valid, bus.done, bus.A, bus.B, bus.vec_idx, bus.loop_cnt);
            end else begin
                e = exp_q.pop_front();
                if (bus.done !== e.done || bus.valid !== !e.done || {bus.A, bus.B} !== e.ab ||
                    bus.vec_idx !== e.idx || bus.loop_cnt !== e.lc) begin
                    errors++;
                    $display("FAIL scoreboard: got done=%b valid=%b AB=%b%b idx=%0d lc=%0d, want done=%b valid=%b AB=%b idx=%0d lc=%0d",
                             bus.done, bus.valid, bus.A, bus.B, bus.vec_idx, bus.loop_cnt,
                             e.done, !e.done, e.ab, e.idx, e.lc);
                end
            end
        end
    end

    // limit>0 pushes only the first 'limit' valid cycles (aborted/reset runs, no done)
    task automatic push_seq(input logic m, input int h, input int l, input int limit);
        exp_t x;
        int n = 0;
        for (int p = 0; p < l; p++)
            for (int v = 0; v < 4; v++)
                for (int k = 0; k < h; k++) begin
                    if (limit == 0 || n < limit) begin
                        x.done = 1'b0;
                        x.ab   = m ? gray_lut[v] : 2'(v);
                        x.idx  = 2'(v);
                        x.lc   = 4'(p);
                        exp_q.push_back(x);
                    end
                    n++;
                end
        if (limit == 0) begin
            x.done = 1'b1;
            x.ab   = 2'b00;
            x.idx  = 2'd0;
            x.lc   = 4'(l);
            exp_q.push_back(x);
        end
    endtask

    task automatic run_case(input logic m, input int h, input int l, input int abort_at,
                            input int pulse_at, input int exp_done, input int exp_lc,
                            input string name);
        int got = 0;
        int hq;
        hq = (h == 0) ? 1 : h;
        push_seq(m, hq, l, abort_at);
        @(negedge clk);
        bus.mode        = m;
        bus.hold_cycles = 8'(h);
        bus.loops       = 4'(l);
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (bus.done && got == 0) got = cyc;
            bus.abort = (cyc == abort_at);
            bus.start = (cyc == pulse_at);
            if (got != 0 && cyc >= got + 2) break;
            if (abort_at > 0 && cyc >= abort_at + 2) break;
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (got != exp_done) begin
            errors++;
            $display("FAIL %s_done_cycle: got %0d, want %0d", name, got, exp_done);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.done !== 1'b0 ||
            bus.A !== 1'b0 || bus.B !== 1'b0 || bus.loop_cnt !== 4'(exp_lc)) begin
            errors++;
            $display("FAIL %s_end_state: busy=%b valid=%b done=%b AB=%b%b lc=%0d, want 0 0 0 00 lc=%0d",
                     name, bus.busy, bus.valid, bus.done, bus.A, bus.B, bus.loop_cnt, exp_lc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.mode        = 1'b0;
        bus.hold_cycles = 8'd0;
        bus.loops       = 4'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.A, bus.B, bus.valid, bus.busy, bus.done, bus.vec_idx, bus.loop_cnt} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state: AB=%b%b valid=%b busy=%b done=%b idx=%0d lc=%0d, want all 0",
                     bus.A, bus.B, bus.valid, bus.busy, bus.done, bus.vec_idx, bus.loop_cnt);
        end
        rst_n = 1'b1;

        run_case(1'b0, 5, 1, 0, 0, 21, 1, "bin_h5_l1");
        run_case(1'b1, 2, 2, 0, 0, 17, 2, "gray_h2_l2");
        run_case(1'b0, 0, 1, 0, 0, 5,  1, "hold0");
        run_case(1'b0, 7, 0, 0, 0, 1,  0, "loops0");
        run_case(1'b0, 5, 1, 7, 0, 0,  0, "abort7");
        run_case(1'b0, 5, 1, 0, 8, 21, 1, "start_in_run");

        push_seq(1'b0, 5, 1, 4);
        @(negedge clk);
        bus.mode        = 1'b0;
        bus.hold_cycles = 8'd5;
        bus.loops       = 4'd1;
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.A !== 1'b0 || bus.B !== 1'b0 || bus.valid !== 1'b0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: AB=%b%b valid=%b busy=%b done=%b, want all 0",
                     bus.A, bus.B, bus.valid, bus.busy, bus.done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_case(1'b0, 5, 1, 0, 0, 21, 1, "after_reset");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
